// File: rtl/range_ctrl.sv
// Range-sweep front panel controller: debounces pushbuttons, launches the range
// datapath with a switch-selected base and steps a display offset over its results.
module range_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int TIMEOUT_CYCLES  = 50000000,
  parameter int RAM_ADDR_BITS   = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [3:0]               KEY,
  input  logic [9:0]               SW,
  input  logic                     done,
  output logic                     go,
  output logic [31:0]              start,
  output logic [RAM_ADDR_BITS-1:0] offset,
  output logic [31:0]              n_disp,
  output logic                     busy,
  output logic                     err
);

  // state  | meaning
  // IDLE   | waiting for KEY[3]; other keys and done ignored
  // LAUNCH | single cycle, go pulse to the datapath
  // RUN    | datapath working; keys ignored, timeout armed
  // SHOW   | results displayed; KEY[0..2] move offset, KEY[3] relaunches
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, SHOW} state_t;

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DB_W-1:0]          DB_LOAD  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RUN_W-1:0]         RUN_LOAD = RUN_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RPT_W-1:0]         RPT_LOAD = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [RAM_ADDR_BITS-1:0] OFF_MAX  = '1;

  logic [3:0]      sync1, sync2, db, press;
  logic [DB_W-1:0] db_cnt [4];

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic             held, rpt_hit, new_press, inc, dec, clr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      press <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        // Down-counter reloads whenever the sample agrees with the debounced value.
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= DB_LOAD;
        end else if (db_cnt[i] == '0) begin
          db_cnt[i] <= DB_LOAD;
          db[i]     <= sync2[i];
          press[i]  <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign held      = ~db[0] | ~db[1];
  assign rpt_hit   = held && (rpt_cnt == '0);
  assign new_press = |press;
  // A fresh press always wins over an auto-repeat step in the same cycle.
  assign inc = press[0] | (~new_press & rpt_hit & ~db[0]);
  assign dec = press[1] | (~new_press & rpt_hit & db[0] & ~db[1]);
  assign clr = press[2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      go      <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      start   <= '0;
      offset  <= '0;
      run_cnt <= '0;
      rpt_cnt <= '0;
    end else begin
      go <= 1'b0;

      if (state != SHOW || new_press || !held || rpt_cnt == '0)
        rpt_cnt <= RPT_LOAD;
      else
        rpt_cnt <= rpt_cnt - 1'b1;

      case (state)
        IDLE, SHOW: begin
          if (press[3]) begin
            start  <= {22'b0, SW};
            offset <= '0;
            err    <= 1'b0;
            go     <= 1'b1;
            busy   <= 1'b1;
            state  <= LAUNCH;
          end else if (state == SHOW) begin
            if (inc) begin
              if (offset != OFF_MAX) offset <= offset + 1'b1;
            end else if (dec) begin
              if (offset != '0) offset <= offset - 1'b1;
            end else if (clr) begin
              offset <= '0;
            end
          end
        end
        LAUNCH: begin
          run_cnt <= RUN_LOAD;
          state   <= RUN;
        end
        RUN: begin
          if (done) begin
            busy  <= 1'b0;
            state <= SHOW;
          end else if (run_cnt == '0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            run_cnt <= run_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign n_disp = start + 32'(offset);

endmodule

// File: doc/range_ctrl.md
RANGE_CTRL -- requirements
Module: range_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000; cycles a key must be stable before its debounced value changes (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 10000000; auto-repeat period while KEY[0] or KEY[1] is held in SHOW (200 ms).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 50000000; maximum RUN duration before abort.
REQ-004 The block SHALL have parameter RAM_ADDR_BITS, default 8; width of offset.
REQ-005 The block SHALL have port clk  input  1  system clock; the only clock.
REQ-006 The block SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-007 The block SHALL have port KEY  input  4  raw pushbuttons, asynchronous, pressed = 0.
REQ-008 The block SHALL have port SW  input  10  switch value used as the range base.
REQ-009 The block SHALL have port done  input  1  completion pulse/level from the range datapath.
REQ-010 The block SHALL have port go  output  1  one-cycle start pulse to the range datapath.
REQ-011 The block SHALL have port start  output  32  base n presented to the range datapath.
REQ-012 The block SHALL have port offset  output  RAM_ADDR_BITS  result index selected for display.
REQ-013 The block SHALL have port n_disp  output  32  start + offset, modulo 2^32.
REQ-014 The block SHALL have port busy  output  1  high while in LAUNCH or RUN.
REQ-015 The block SHALL have port err  output  1  sticky flag; set on RUN timeout.

Function
REQ-016 Each KEY bit SHALL pass through a 2-flop synchronizer, then a debouncer that updates its output only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-017 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; releases SHALL generate no event.
REQ-018 The FSM SHALL have states IDLE, LAUNCH, RUN, SHOW.
REQ-019 In IDLE or SHOW, a KEY[3] press SHALL load start <= zero-extended SW, offset <= 0, clear err, and go to LAUNCH; it SHALL take priority over KEY[0..2].
REQ-020 LAUNCH SHALL last exactly one cycle with go=1, then go to RUN; go SHALL be 0 in every other state.
REQ-021 RUN SHALL count cycles; done=1 SHALL move to SHOW on the next edge; if the count reaches TIMEOUT_CYCLES without done, the FSM SHALL set err=1 and move to IDLE.
REQ-022 In RUN, all key events SHALL be ignored, and start and offset SHALL remain constant.
REQ-023 In IDLE, done SHALL be ignored, and KEY[0..2] events SHALL have no effect.
REQ-024 In SHOW, a KEY[0] press SHALL increment offset, saturating at 2^RAM_ADDR_BITS-1.
REQ-025 In SHOW, a KEY[1] press SHALL decrement offset, saturating at 0.
REQ-026 In SHOW, a KEY[2] press SHALL clear offset to 0.
REQ-027 When KEY[0..2] events coincide in the same cycle, priority SHALL be KEY[0] > KEY[1] > KEY[2]; only one action SHALL apply per cycle.
REQ-028 In SHOW, while KEY[0] or KEY[1] stays debounced-pressed, an additional step SHALL occur every REPEAT_CYCLES after the press event; the repeat timer SHALL reset on release or on any new press.
REQ-029 n_disp SHALL be combinational start + offset, with offset zero-extended and wrapping modulo 2^32.
REQ-030 start and offset SHALL hold their values through SHOW and back to IDLE; only KEY[3] or reset SHALL change start.

Reset
REQ-031 When reset_n=0 at a clk edge, the block SHALL enter IDLE with go=0, busy=0, err=0, start=0, offset=0, all counters 0, and debounced keys = released (1).
REQ-032 Reset asserted during any state, including mid-RUN, SHALL take effect on that edge; no go pulse SHALL follow the reset.

Verification
REQ-033 The bench SHALL use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16, TIMEOUT_CYCLES=64 for all of the following.
REQ-034 Launch: SW=10'd27, press KEY[3] for 10 cycles -> exactly one go pulse, start=27, busy=1; done=1 at RUN cycle 20 -> SHOW, busy=0, n_disp=27.
REQ-035 Bounce: toggle KEY[3] every 2 cycles for 12 cycles, then release -> no go pulse, state stays IDLE.
REQ-036 Offset saturation: in SHOW, press KEY[1] -> offset stays 0; hold KEY[0] for 16*300 cycles -> offset saturates at 255, n_disp=start+255; a KEY[0]/KEY[1] simultaneous press at offset 5 -> offset 6.
REQ-037 Timeout: launch with done held 0 -> at RUN cycle 64, err=1, state IDLE, busy=0; the next KEY[3] press clears err.
REQ-038 Reset mid-RUN: assert reset_n=0 for 1 cycle at RUN cycle 10 -> start=0, offset=0, busy=0, IDLE, no further go pulse.
REQ-039 Ignore in RUN: KEY[0] and KEY[3] presses during RUN -> no offset change, no second go pulse.
